// File: rtl/prbs_pkg.sv
// Shared definitions for the spin random-word generator and its receive-side checker.
package prbs_pkg;

  localparam int unsigned PrbsWordW = 12;
  localparam int unsigned PrbsLfsrW = 8;

  // Feedback taps: new MSB = s[TapA] ^ s[TapB], output s[0], shift right.
  localparam int unsigned TapA = 0;
  localparam int unsigned TapB = 1;

  typedef enum logic [1:0] {
    StSeed = 2'd0,
    StAcq  = 2'd1,
    StLock = 2'd2,
    StLost = 2'd3
  } prbs_state_e;

endpackage

// File: rtl/prbs_lfsr_step_n.sv
// Advances the LFSR WORD_W steps, returning the emitted bits (bit 0 first) and the final state.
module prbs_lfsr_step_n
  import prbs_pkg::*;
#(
  parameter int unsigned WORD_W = PrbsWordW,
  parameter int unsigned LFSR_W = PrbsLfsrW
) (
  input  logic [LFSR_W-1:0] state,
  output logic [WORD_W-1:0] bits,
  output logic [LFSR_W-1:0] next_state
);

  logic [LFSR_W-1:0] s;

  always_comb begin
    s    = state;
    bits = '0;
    for (int i = 0; i < WORD_W; i++) begin
      bits[i] = s[0];
      s       = {s[TapA] ^ s[TapB], s[LFSR_W-1:1]};
    end
    next_state = s;
  end

endmodule

// File: rtl/prbs_word_checker.sv
// Self-synchronising checker for the 12-bit PRBS word stream: acquires, locks, counts bit errors.
// Build option PRBS_CHK_RESYNC_EN: loss of lock returns to seeding instead of a sticky LOST state.
module prbs_word_checker
  import prbs_pkg::*;
#(
  parameter int unsigned WORD_W      = PrbsWordW,
  parameter int unsigned LFSR_W      = PrbsLfsrW,
  parameter int unsigned LOCK_WORDS  = 4,
  parameter int unsigned LOSS_THRESH = 3,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_word,
  input  logic              clr,
  output logic              locked,
  output logic              lost,
  output logic              err_pulse,
  output logic [3:0]        nerr,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int unsigned CleanW = $clog2(LOCK_WORDS + 1);

  prbs_state_e       state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [CleanW-1:0] clean_q, clean_d;
  logic              err_pulse_q, err_pulse_d;
  logic [3:0]        nerr_q, nerr_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;

  // Tracking path: prediction from the local state only, never from received bits.
  logic [WORD_W-1:0] trk_bits;
  logic [LFSR_W-1:0] trk_next;

  prbs_lfsr_step_n #(
    .WORD_W (WORD_W),
    .LFSR_W (LFSR_W)
  ) u_step (
    .state      (lfsr_q),
    .bits       (trk_bits),
    .next_state (trk_next)
  );

  // Seed path: treat the low LFSR_W bits of the word as the state and check the rest.
  logic [WORD_W-1:0] seed_bits;
  logic [LFSR_W-1:0] seed_next;
  logic [LFSR_W-1:0] seed_s;
  logic              seed_ok;

  always_comb begin
    seed_s    = in_word[LFSR_W-1:0];
    seed_bits = '0;
    for (int i = 0; i < WORD_W; i++) begin
      seed_bits[i] = seed_s[0];
      seed_s       = {seed_s[TapA] ^ seed_s[TapB], seed_s[LFSR_W-1:1]};
    end
    seed_next = seed_s;
    seed_ok   = (in_word[LFSR_W-1:0] != '0) &&
                (seed_bits[WORD_W-1:LFSR_W] == in_word[WORD_W-1:LFSR_W]);
  end

  logic [WORD_W-1:0] diff;
  logic [3:0]        nerr_now;
  logic [CNT_W:0]    err_sum;
  logic [CNT_W-1:0]  err_sat;
  logic [CNT_W-1:0]  word_sat;

  always_comb begin
    diff     = trk_bits ^ in_word;
    nerr_now = '0;
    for (int i = 0; i < WORD_W; i++) begin
      nerr_now = nerr_now + 4'(diff[i]);
    end
    err_sum  = {1'b0, err_cnt_q} + {{(CNT_W - 3){1'b0}}, nerr_now};
    err_sat  = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    word_sat = (&word_cnt_q) ? word_cnt_q : word_cnt_q + 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    clean_d     = clean_q;
    err_pulse_d = 1'b0;
    nerr_d      = nerr_q;
    err_cnt_d   = err_cnt_q;
    word_cnt_d  = word_cnt_q;

    if (clr) begin
      state_d    = StSeed;
      clean_d    = '0;
      nerr_d     = '0;
      err_cnt_d  = '0;
      word_cnt_d = '0;
    end else if (in_valid) begin
      case (state_q)
        StSeed: begin
          if (seed_ok) begin
            lfsr_d  = seed_next;
            clean_d = CleanW'(1);
            state_d = StAcq;
          end
        end
        StAcq: begin
          if (nerr_now == '0) begin
            lfsr_d = trk_next;
            if (clean_q >= CleanW'(LOCK_WORDS - 1)) begin
              clean_d = CleanW'(LOCK_WORDS);
              state_d = StLock;
            end else begin
              clean_d = clean_q + 1'b1;
            end
          end else if (seed_ok) begin
            lfsr_d  = seed_next;
            clean_d = CleanW'(1);
          end else begin
            clean_d = '0;
            state_d = StSeed;
          end
        end
        StLock: begin
          lfsr_d      = trk_next;
          nerr_d      = nerr_now;
          err_cnt_d   = err_sat;
          word_cnt_d  = word_sat;
          err_pulse_d = (nerr_now != '0);
          if (nerr_now >= 4'(LOSS_THRESH)) begin
`ifdef PRBS_CHK_RESYNC_EN
            clean_d = '0;
            state_d = StSeed;
`else
            state_d = StLost;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StSeed;
      lfsr_q      <= '0;
      clean_q     <= '0;
      err_pulse_q <= 1'b0;
      nerr_q      <= '0;
      err_cnt_q   <= '0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      clean_q     <= clean_d;
      err_pulse_q <= err_pulse_d;
      nerr_q      <= nerr_d;
      err_cnt_q   <= err_cnt_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign locked    = (state_q == StLock);
  assign lost      = (state_q == StLost);
  assign err_pulse = err_pulse_q;
  assign nerr      = nerr_q;
  assign err_cnt   = err_cnt_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_prbs_word_checker.sv
// Directed bench for prbs_word_checker built with narrow (4-bit) counters to reach saturation.
module tb_prbs_word_checker;
  import prbs_pkg::*;

  localparam int unsigned CntW = 4;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic [11:0]     in_word;
  logic            clr;
  logic            locked;
  logic            lost;
  logic            err_pulse;
  logic [3:0]      nerr;
  logic [CntW-1:0] err_cnt;
  logic [CntW-1:0] word_cnt;

  int checks   = 0;
  int failures = 0;

  logic [7:0] gen_q;

  prbs_word_checker #(
    .WORD_W      (12),
    .LFSR_W      (8),
    .LOCK_WORDS  (4),
    .LOSS_THRESH (3),
    .CNT_W       (CntW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_word   (in_word),
    .clr       (clr),
    .locked    (locked),
    .lost      (lost),
    .err_pulse (err_pulse),
    .nerr      (nerr),
    .err_cnt   (err_cnt),
    .word_cnt  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, then return at the following negedge with outputs settled.
  task automatic drive(input logic [11:0] w, input logic v, input logic c);
    @(negedge clk);
    in_word  = w;
    in_valid = v;
    clr      = c;
    @(negedge clk);
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  // Next clean stream word from the reference generator, XORed with an error mask.
  task automatic send_gen(input logic [11:0] mask);
    logic [11:0] w;
    for (int i = 0; i < 12; i++) begin
      w[i]  = gen_q[0];
      gen_q = {gen_q[0] ^ gen_q[1], gen_q[7:1]};
    end
    drive(w ^ mask, 1'b1, 1'b0);
  endtask

  task automatic relock();
    for (int i = 0; i < 4; i++) send_gen(12'h000);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_word  = '0;
    clr      = 1'b0;
    gen_q    = 8'hB4;
    #23;
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_lost", 32'(lost), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_nerr", 32'(nerr), 32'd0);
    check("rst_pulse", 32'(err_pulse), 32'd0);
    rst_n = 1'b1;

    // Bad seeds: zero low byte, wrong high nibble.
    drive(12'h000, 1'b1, 1'b0);
    check("zero_seed_state", 32'(dut.state_q), 32'(StSeed));
    drive(12'h0B4, 1'b1, 1'b0);
    check("bad_nibble_state", 32'(dut.state_q), 32'(StSeed));
    drive(12'hE00, 1'b1, 1'b0);
    check("zero_seed2_state", 32'(dut.state_q), 32'(StSeed));
    check("bad_seed_locked", 32'(locked), 32'd0);

    // Acquisition from seed B4: first words are 12'hEB4, 12'h19E.
    drive(12'hEB4, 1'b1, 1'b0);
    check("acq_w1_state", 32'(dut.state_q), 32'(StAcq));
    check("acq_w1_locked", 32'(locked), 32'd0);
    drive(12'h19E, 1'b1, 1'b0);
    gen_q = 8'hB4;
    for (int i = 0; i < 24; i++) gen_q = {gen_q[0] ^ gen_q[1], gen_q[7:1]};
    send_gen(12'h000);
    check("acq_w3_locked", 32'(locked), 32'd0);
    send_gen(12'h000);
    check("acq_w4_locked", 32'(locked), 32'd1);
    check("acq_err_cnt", 32'(err_cnt), 32'd0);
    check("acq_word_cnt", 32'(word_cnt), 32'd0);

    send_gen(12'h000);
    check("clean_word_cnt", 32'(word_cnt), 32'd1);
    check("clean_nerr", 32'(nerr), 32'd0);
    check("clean_pulse", 32'(err_pulse), 32'd0);

    // Single-bit error on bit 5.
    send_gen(12'h020);
    check("e1_nerr", 32'(nerr), 32'd1);
    check("e1_pulse", 32'(err_pulse), 32'd1);
    check("e1_err_cnt", 32'(err_cnt), 32'd1);
    check("e1_word_cnt", 32'(word_cnt), 32'd2);
    check("e1_locked", 32'(locked), 32'd1);
    drive(12'h000, 1'b0, 1'b0);
    check("e1_pulse_drop", 32'(err_pulse), 32'd0);

    send_gen(12'h801);
    check("e2a_err_cnt", 32'(err_cnt), 32'd3);
    send_gen(12'h084);
    check("e2b_err_cnt", 32'(err_cnt), 32'd5);
    check("e2b_word_cnt", 32'(word_cnt), 32'd4);
    check("e2b_locked", 32'(locked), 32'd1);

    // clr wins over a same-cycle (3-error) word.
    drive(12'h007, 1'b1, 1'b1);
    check("clr_err_cnt", 32'(err_cnt), 32'd0);
    check("clr_word_cnt", 32'(word_cnt), 32'd0);
    check("clr_nerr", 32'(nerr), 32'd0);
    check("clr_state", 32'(dut.state_q), 32'(StSeed));
    check("clr_locked", 32'(locked), 32'd0);

    relock();
    check("relock1", 32'(locked), 32'd1);

    // Loss of lock with three flipped bits.
    send_gen(12'h212);
    check("loss_nerr", 32'(nerr), 32'd3);
    check("loss_err_cnt", 32'(err_cnt), 32'd3);
    check("loss_word_cnt", 32'(word_cnt), 32'd1);
    check("loss_locked", 32'(locked), 32'd0);
`ifdef PRBS_CHK_RESYNC_EN
    check("loss_lost", 32'(lost), 32'd0);
    check("loss_state", 32'(dut.state_q), 32'(StSeed));
    relock();
    check("resync_locked", 32'(locked), 32'd1);
    check("resync_err_cnt", 32'(err_cnt), 32'd3);
    check("resync_word_cnt", 32'(word_cnt), 32'd1);
`else
    check("loss_lost", 32'(lost), 32'd1);
    send_gen(12'h000);
    check("lost_hold_err", 32'(err_cnt), 32'd3);
    check("lost_hold_word", 32'(word_cnt), 32'd1);
    check("lost_sticky", 32'(lost), 32'd1);
`endif

    drive(12'h000, 1'b0, 1'b1);
    check("clr2_lost", 32'(lost), 32'd0);
    relock();
    check("relock2", 32'(locked), 32'd1);

    // Saturation: two errors per word into a 4-bit error counter.
    for (int i = 0; i < 7; i++) send_gen(12'h410);
    check("sat7_err_cnt", 32'(err_cnt), 32'd14);
    check("sat7_word_cnt", 32'(word_cnt), 32'd7);
    send_gen(12'h410);
    check("sat8_err_cnt", 32'(err_cnt), 32'd15);
    check("sat8_word_cnt", 32'(word_cnt), 32'd8);
    send_gen(12'h410);
    check("sat9_err_cnt", 32'(err_cnt), 32'd15);
    check("sat9_word_cnt", 32'(word_cnt), 32'd9);
    check("sat9_locked", 32'(locked), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
